pipe_hazard_ctrl: RTL

- Central pipeline sequencer for the RV32I core.
- Generates stall, flush and PC-redirect controls for the PC register, the IF/ID register and the ID/EX register.
- Arbitrates three competing events: external hold (fetch/data bus wait), branch/jump taken in EX, and load-use hazard against the decoder's rs1/rs2.
- Tracks multi-cycle hold with a timeout monitor; performs a one-cycle boot flush after reset.

---
 rtl/RV32I_Inst_Pkg.sv | 6 +
 rtl/hold_timer.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/RV32I_Inst_Pkg.sv
// RV32I_Inst_Pkg: shared RV32I encodings and pipeline-control state type
package RV32I_Inst_Pkg;
  typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HOLD} pipe_ctrl_state_e;
  localparam logic [6:0] RV32I_OP_LOAD = 7'b0000011;
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: saturating hold-length counter with sticky timeout flag
module hold_timer #(
  parameter int HOLD_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic err
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_TIMEOUT);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // start loads 1 for the first hold cycle, run extends it up to LIMIT, anything else clears
  always_comb cnt_nxt = start ? CNT_W'(1) : run ? (cnt == LIMIT ? cnt : cnt + 1'b1) : '0;
  // counter register; err latches the cycle the count reaches LIMIT and holds until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err | (cnt_nxt == LIMIT);
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RV32I stall/flush/redirect sequencer; perf counters under PIPE_HAZARD_CTRL_PERF_EN
module pipe_hazard_ctrl
  import RV32I_Inst_Pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int HOLD_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_req,
  input  logic        jump_en_ex,
  input  logic [31:0] jump_addr_ex,
  input  logic        ex_is_load,
  input  logic        ex_reg_wen,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_en,
  output logic [31:0] redirect_addr,
  output logic        hold_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  pipe_ctrl_state_e state, state_nxt;
  logic load_use, jump_take, bubble_take;
  assign load_use = ex_is_load & ex_reg_wen & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= PC_BOOT;
    else state <= state_nxt;
  end
  // next state and controls; in RUN hold beats jump beats load-use
  always_comb begin
    state_nxt = state;
    stall_pc = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    redirect_en = 1'b0;
    redirect_addr = '0;
    jump_take = 1'b0;
    bubble_take = 1'b0;
    case (state)
      PC_BOOT: begin
        state_nxt = PC_RUN;
        redirect_en = 1'b1;
        redirect_addr = RESET_PC;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      PC_RUN: begin
        if (hold_req) begin
          state_nxt = PC_HOLD;
          stall_pc = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
        end else if (jump_en_ex) begin
          jump_take = 1'b1;
          redirect_en = 1'b1;
          redirect_addr = jump_addr_ex;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          bubble_take = 1'b1;
          stall_pc = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      PC_HOLD: begin
        state_nxt = hold_req ? PC_HOLD : PC_RUN;
        stall_pc = 1'b1;
        stall_if_id = 1'b1;
        stall_id_ex = 1'b1;
      end
      default: state_nxt = PC_BOOT;
    endcase
  end
  hold_timer #(.HOLD_TIMEOUT(HOLD_TIMEOUT), .CNT_W(CNT_W)) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state == PC_RUN && hold_req),
    .run  (state == PC_HOLD && hold_req),
    .err  (hold_err)
  );
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(stall_pc);
      perf_flush_cnt <= perf_flush_cnt + 32'(jump_take);
      perf_bubble_cnt <= perf_bubble_cnt + 32'(bubble_take);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, jump_take, bubble_take};
`endif
endmodule
